hbram_axi_arb: RTL and testbench

Two-port AXI arbiter that shares the single combined address channel (arw) and the write, response and read channels of the `hbram` HyperRAM controller between two requesters. Example requesters are a DMA/frame writer and a display/readback engine. It sits directly in front of `hbram` in the `io_axi_clk` domain. It applies round-robin arbitration to arw and locks the W channel to the owner of the current write burst. It routes B/R responses by ID tag and bounds each port's outstanding transactions.

---
 rtl/hbram_arb_pkg.sv | 25 ++
 rtl/hbram_arb_credit.sv | 34 +++
 rtl/hbram_axi_arb.sv | 212 +++++++++++++++++++++
 tb/tb_hbram_axi_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbram_arb_pkg.sv
// Shared types and constants for the two-port HyperRAM AXI arbiter.
package hbram_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;
  localparam int MID_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARW_HOLD,
    W_BURST
  } arb_state_e;

  // arw payload minus the ID, which is widened with the port index separately
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [1:0]        lock;
    logic              write;
  } arw_pld_t;

endpackage

// File: rtl/hbram_arb_credit.sv
// Per-port outstanding-transaction counter; saturates at 0 and flags stray responses.
module hbram_arb_credit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec_b,
  input  logic dec_r,
  output logic full,
  output logic err
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

  logic [3:0]        cnt_q, cnt_d;
  logic signed [5:0] sum;

  // B and R for the same port may both complete in one cycle
  always_comb begin
    sum   = $signed({2'b00, cnt_q}) + $signed({5'b0, inc})
          - $signed({5'b0, dec_b}) - $signed({5'b0, dec_r});
    err   = (sum < 0);
    cnt_d = err ? 4'd0 : sum[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign full = (cnt_q >= MAX_C);

endmodule

// File: rtl/hbram_axi_arb.sv
// Round-robin arbiter sharing one hbram AXI port (combined arw, W, B, R) between two requesters.
module hbram_axi_arb
  import hbram_arb_pkg::*;
#(
  parameter int ID_W            = 7,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              io_axi_clk,
  input  logic              rst_n,
  // requester 0
  input  logic [ADDR_W-1:0] s0_arw_addr,
  input  logic [7:0]        s0_arw_len,
  input  logic [2:0]        s0_arw_size,
  input  logic [1:0]        s0_arw_burst,
  input  logic [1:0]        s0_arw_lock,
  input  logic              s0_arw_write,
  input  logic [ID_W-1:0]   s0_arw_id,
  input  logic              s0_arw_valid,
  output logic              s0_arw_ready,
  input  logic [DATA_W-1:0] s0_w_data,
  input  logic [STRB_W-1:0] s0_w_strb,
  input  logic              s0_w_last,
  input  logic              s0_w_valid,
  output logic              s0_w_ready,
  output logic              s0_b_valid,
  output logic [ID_W-1:0]   s0_b_id,
  input  logic              s0_b_ready,
  output logic              s0_r_valid,
  output logic [DATA_W-1:0] s0_r_data,
  output logic [ID_W-1:0]   s0_r_id,
  output logic              s0_r_last,
  output logic [1:0]        s0_r_resp,
  input  logic              s0_r_ready,
  // requester 1
  input  logic [ADDR_W-1:0] s1_arw_addr,
  input  logic [7:0]        s1_arw_len,
  input  logic [2:0]        s1_arw_size,
  input  logic [1:0]        s1_arw_burst,
  input  logic [1:0]        s1_arw_lock,
  input  logic              s1_arw_write,
  input  logic [ID_W-1:0]   s1_arw_id,
  input  logic              s1_arw_valid,
  output logic              s1_arw_ready,
  input  logic [DATA_W-1:0] s1_w_data,
  input  logic [STRB_W-1:0] s1_w_strb,
  input  logic              s1_w_last,
  input  logic              s1_w_valid,
  output logic              s1_w_ready,
  output logic              s1_b_valid,
  output logic [ID_W-1:0]   s1_b_id,
  input  logic              s1_b_ready,
  output logic              s1_r_valid,
  output logic [DATA_W-1:0] s1_r_data,
  output logic [ID_W-1:0]   s1_r_id,
  output logic              s1_r_last,
  output logic [1:0]        s1_r_resp,
  input  logic              s1_r_ready,
  // controller side
  output logic              m_arw_valid,
  input  logic              m_arw_ready,
  output logic [ADDR_W-1:0] m_arw_payload_addr,
  output logic [7:0]        m_arw_payload_len,
  output logic [2:0]        m_arw_payload_size,
  output logic [1:0]        m_arw_payload_burst,
  output logic [1:0]        m_arw_payload_lock,
  output logic              m_arw_payload_write,
  output logic [ID_W:0]     m_arw_payload_id,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  output logic [DATA_W-1:0] m_w_payload_data,
  output logic [STRB_W-1:0] m_w_payload_strb,
  output logic              m_w_payload_last,
  output logic [ID_W:0]     m_w_payload_id,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  input  logic [ID_W:0]     m_b_payload_id,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [DATA_W-1:0] m_r_payload_data,
  input  logic [ID_W:0]     m_r_payload_id,
  input  logic [1:0]        m_r_payload_resp,
  input  logic              m_r_payload_last,
  output logic              arb_err
);

  arb_state_e       state_q, state_d;
  arw_pld_t         pld_q;
  logic [ID_W:0]    id_q;
  logic             last_grant_q;
  logic             err_q;
  logic             full0, full1, err0, err1;
  logic             elig0, elig1, gnt1;
  logic             hs0, hs1, in_w, owner;
  logic             b_sel, r_sel;
  logic             b_hs, r_hs_last;

  assign elig0 = s0_arw_valid & ~full0;
  assign elig1 = s1_arw_valid & ~full1;
  // on a tie the port that did not win last time gets the grant
  assign gnt1  = elig1 & (~elig0 | ~last_grant_q);
  assign hs0   = s0_arw_valid & s0_arw_ready;
  assign hs1   = s1_arw_valid & s1_arw_ready;
  assign in_w  = (state_q == W_BURST);
  assign owner = id_q[ID_W];

  always_comb begin
    state_d      = state_q;
    s0_arw_ready = 1'b0;
    s1_arw_ready = 1'b0;
    case (state_q)
      IDLE: begin
        s0_arw_ready = elig0 & ~gnt1;
        s1_arw_ready = gnt1;
        if (elig0 | elig1) state_d = ARW_HOLD;
      end
      ARW_HOLD: begin
        if (m_arw_ready) state_d = pld_q.write ? W_BURST : IDLE;
      end
      W_BURST: begin
        if (m_w_valid && m_w_ready && m_w_payload_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pld_q        <= '0;
      id_q         <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err0 | err1;
      if (hs0) begin
        pld_q        <= '{s0_arw_addr, s0_arw_len, s0_arw_size, s0_arw_burst,
                          s0_arw_lock, s0_arw_write};
        id_q         <= {1'b0, s0_arw_id};
        last_grant_q <= 1'b0;
      end else if (hs1) begin
        pld_q        <= '{s1_arw_addr, s1_arw_len, s1_arw_size, s1_arw_burst,
                          s1_arw_lock, s1_arw_write};
        id_q         <= {1'b1, s1_arw_id};
        last_grant_q <= 1'b1;
      end
    end
  end

  assign m_arw_valid         = (state_q == ARW_HOLD);
  assign m_arw_payload_addr  = pld_q.addr;
  assign m_arw_payload_len   = pld_q.len;
  assign m_arw_payload_size  = pld_q.size;
  assign m_arw_payload_burst = pld_q.burst;
  assign m_arw_payload_lock  = pld_q.lock;
  assign m_arw_payload_write = pld_q.write;
  assign m_arw_payload_id    = id_q;
  assign arb_err             = err_q;

  // W is a pure mux locked to the owner of the burst accepted last
  assign m_w_valid        = in_w & (owner ? s1_w_valid : s0_w_valid);
  assign m_w_payload_data = owner ? s1_w_data : s0_w_data;
  assign m_w_payload_strb = owner ? s1_w_strb : s0_w_strb;
  assign m_w_payload_last = owner ? s1_w_last : s0_w_last;
  assign m_w_payload_id   = id_q;
  assign s0_w_ready       = in_w & ~owner & m_w_ready;
  assign s1_w_ready       = in_w &  owner & m_w_ready;

  assign b_sel      = m_b_payload_id[ID_W];
  assign s0_b_valid = m_b_valid & ~b_sel;
  assign s1_b_valid = m_b_valid &  b_sel;
  assign s0_b_id    = m_b_payload_id[ID_W-1:0];
  assign s1_b_id    = m_b_payload_id[ID_W-1:0];
  assign m_b_ready  = b_sel ? s1_b_ready : s0_b_ready;

  assign r_sel      = m_r_payload_id[ID_W];
  assign s0_r_valid = m_r_valid & ~r_sel;
  assign s1_r_valid = m_r_valid &  r_sel;
  assign s0_r_data  = m_r_payload_data;
  assign s1_r_data  = m_r_payload_data;
  assign s0_r_id    = m_r_payload_id[ID_W-1:0];
  assign s1_r_id    = m_r_payload_id[ID_W-1:0];
  assign s0_r_last  = m_r_payload_last;
  assign s1_r_last  = m_r_payload_last;
  assign s0_r_resp  = m_r_payload_resp;
  assign s1_r_resp  = m_r_payload_resp;
  assign m_r_ready  = r_sel ? s1_r_ready : s0_r_ready;

  assign b_hs      = m_b_valid & m_b_ready;
  assign r_hs_last = m_r_valid & m_r_ready & m_r_payload_last;

  hbram_arb_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cred0 (
    .clk   (io_axi_clk),
    .rst_n (rst_n),
    .inc   (hs0),
    .dec_b (b_hs & ~b_sel),
    .dec_r (r_hs_last & ~r_sel),
    .full  (full0),
    .err   (err0)
  );

  hbram_arb_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cred1 (
    .clk   (io_axi_clk),
    .rst_n (rst_n),
    .inc   (hs1),
    .dec_b (b_hs & b_sel),
    .dec_r (r_hs_last & r_sel),
    .full  (full1),
    .err   (err1)
  );

endmodule

// File: tb/tb_hbram_axi_arb.sv
// Directed self-checking bench for hbram_axi_arb.
module tb_hbram_axi_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  s0_arw_addr, s1_arw_addr;
  logic [7:0]   s0_arw_len, s1_arw_len;
  logic [2:0]   s0_arw_size, s1_arw_size;
  logic [1:0]   s0_arw_burst, s1_arw_burst, s0_arw_lock, s1_arw_lock;
  logic         s0_arw_write, s1_arw_write;
  logic [6:0]   s0_arw_id, s1_arw_id;
  logic         s0_arw_valid, s1_arw_valid, s0_arw_ready, s1_arw_ready;
  logic [127:0] s0_w_data, s1_w_data;
  logic [15:0]  s0_w_strb, s1_w_strb;
  logic         s0_w_last, s1_w_last, s0_w_valid, s1_w_valid, s0_w_ready, s1_w_ready;
  logic         s0_b_valid, s1_b_valid, s0_b_ready, s1_b_ready;
  logic [6:0]   s0_b_id, s1_b_id, s0_r_id, s1_r_id;
  logic         s0_r_valid, s1_r_valid, s0_r_last, s1_r_last, s0_r_ready, s1_r_ready;
  logic [127:0] s0_r_data, s1_r_data;
  logic [1:0]   s0_r_resp, s1_r_resp;
  logic         m_arw_valid, m_arw_ready;
  logic [31:0]  m_arw_payload_addr;
  logic [7:0]   m_arw_payload_len;
  logic [2:0]   m_arw_payload_size;
  logic [1:0]   m_arw_payload_burst, m_arw_payload_lock;
  logic         m_arw_payload_write;
  logic [7:0]   m_arw_payload_id;
  logic         m_w_valid, m_w_ready, m_w_payload_last;
  logic [127:0] m_w_payload_data;
  logic [15:0]  m_w_payload_strb;
  logic [7:0]   m_w_payload_id;
  logic         m_b_valid, m_b_ready;
  logic [7:0]   m_b_payload_id;
  logic         m_r_valid, m_r_ready, m_r_payload_last;
  logic [127:0] m_r_payload_data;
  logic [7:0]   m_r_payload_id;
  logic [1:0]   m_r_payload_resp;
  logic         arb_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hbram_axi_arb #(.ID_W(7), .MAX_OUTSTANDING(4)) dut (
    .io_axi_clk(clk), .rst_n(rst_n),
    .s0_arw_addr(s0_arw_addr), .s0_arw_len(s0_arw_len), .s0_arw_size(s0_arw_size),
    .s0_arw_burst(s0_arw_burst), .s0_arw_lock(s0_arw_lock), .s0_arw_write(s0_arw_write),
    .s0_arw_id(s0_arw_id), .s0_arw_valid(s0_arw_valid), .s0_arw_ready(s0_arw_ready),
    .s0_w_data(s0_w_data), .s0_w_strb(s0_w_strb), .s0_w_last(s0_w_last),
    .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready),
    .s0_b_valid(s0_b_valid), .s0_b_id(s0_b_id), .s0_b_ready(s0_b_ready),
    .s0_r_valid(s0_r_valid), .s0_r_data(s0_r_data), .s0_r_id(s0_r_id),
    .s0_r_last(s0_r_last), .s0_r_resp(s0_r_resp), .s0_r_ready(s0_r_ready),
    .s1_arw_addr(s1_arw_addr), .s1_arw_len(s1_arw_len), .s1_arw_size(s1_arw_size),
    .s1_arw_burst(s1_arw_burst), .s1_arw_lock(s1_arw_lock), .s1_arw_write(s1_arw_write),
    .s1_arw_id(s1_arw_id), .s1_arw_valid(s1_arw_valid), .s1_arw_ready(s1_arw_ready),
    .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb), .s1_w_last(s1_w_last),
    .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready),
    .s1_b_valid(s1_b_valid), .s1_b_id(s1_b_id), .s1_b_ready(s1_b_ready),
    .s1_r_valid(s1_r_valid), .s1_r_data(s1_r_data), .s1_r_id(s1_r_id),
    .s1_r_last(s1_r_last), .s1_r_resp(s1_r_resp), .s1_r_ready(s1_r_ready),
    .m_arw_valid(m_arw_valid), .m_arw_ready(m_arw_ready),
    .m_arw_payload_addr(m_arw_payload_addr), .m_arw_payload_len(m_arw_payload_len),
    .m_arw_payload_size(m_arw_payload_size), .m_arw_payload_burst(m_arw_payload_burst),
    .m_arw_payload_lock(m_arw_payload_lock), .m_arw_payload_write(m_arw_payload_write),
    .m_arw_payload_id(m_arw_payload_id),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_payload_data(m_w_payload_data),
    .m_w_payload_strb(m_w_payload_strb), .m_w_payload_last(m_w_payload_last),
    .m_w_payload_id(m_w_payload_id),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_payload_id(m_b_payload_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_payload_data(m_r_payload_data),
    .m_r_payload_id(m_r_payload_id), .m_r_payload_resp(m_r_payload_resp),
    .m_r_payload_last(m_r_payload_last),
    .arb_err(arb_err)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    s0_arw_addr = 32'h0; s0_arw_len = 8'd0; s0_arw_size = 3'd4; s0_arw_burst = 2'd1;
    s0_arw_lock = 2'd0; s0_arw_write = 1'b0; s0_arw_id = 7'd0; s0_arw_valid = 1'b0;
    s1_arw_addr = 32'h0; s1_arw_len = 8'd0; s1_arw_size = 3'd4; s1_arw_burst = 2'd1;
    s1_arw_lock = 2'd0; s1_arw_write = 1'b0; s1_arw_id = 7'd0; s1_arw_valid = 1'b0;
    s0_w_data = '0; s0_w_strb = '1; s0_w_last = 1'b0; s0_w_valid = 1'b0;
    s1_w_data = '0; s1_w_strb = '1; s1_w_last = 1'b0; s1_w_valid = 1'b0;
    s0_b_ready = 1'b1; s1_b_ready = 1'b1; s0_r_ready = 1'b1; s1_r_ready = 1'b1;
    m_arw_ready = 1'b1; m_w_ready = 1'b1;
    m_b_valid = 1'b0; m_b_payload_id = 8'h00;
    m_r_valid = 1'b0; m_r_payload_data = '0; m_r_payload_id = 8'h00;
    m_r_payload_resp = 2'd0; m_r_payload_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    do_reset();

    // reset state
    #1;
    check_eq("rst_m_arw_valid", m_arw_valid, 1'b0);
    check_eq("rst_s0_arw_ready", s0_arw_ready, 1'b0);
    check_eq("rst_m_w_valid", m_w_valid, 1'b0);
    check_eq("rst_arb_err", arb_err, 1'b0);
    check_eq("rst_cnt0", dut.u_cred0.cnt_q, 4'd0);
    check_eq("rst_arw_id", m_arw_payload_id, 8'h00);

    // single read from s0, id 5, len 3
    s0_arw_valid = 1'b1; s0_arw_id = 7'd5; s0_arw_len = 8'd3; s0_arw_addr = 32'h1000;
    #1;
    check_eq("rd_s0_ready", s0_arw_ready, 1'b1);
    check_eq("rd_s1_ready", s1_arw_ready, 1'b0);
    step();
    s0_arw_valid = 1'b0;
    #1;
    check_eq("rd_m_arw_valid", m_arw_valid, 1'b1);
    check_eq("rd_m_arw_id", m_arw_payload_id, 8'h05);
    check_eq("rd_m_arw_len", m_arw_payload_len, 8'd3);
    check_eq("rd_m_arw_addr", m_arw_payload_addr, 32'h1000);
    check_eq("rd_cnt0_1", dut.u_cred0.cnt_q, 4'd1);
    step();
    #1;
    check_eq("rd_idle_after", m_arw_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1'b1; m_r_payload_id = 8'h05; m_r_payload_data = 128'(i + 16'hA0);
      m_r_payload_last = (i == 3);
      #1;
      check_eq("rd_s0_r_valid", s0_r_valid, 1'b1);
      check_eq("rd_s1_r_valid", s1_r_valid, 1'b0);
      check_eq("rd_s0_r_id", s0_r_id, 7'd5);
      check_eq("rd_s0_r_data", s0_r_data, 128'(i + 16'hA0));
      check_eq("rd_s0_r_last", s0_r_last, (i == 3));
      check_eq("rd_m_r_ready", m_r_ready, 1'b1);
      step();
    end
    m_r_valid = 1'b0; m_r_payload_last = 1'b0;
    #1;
    check_eq("rd_cnt0_0", dut.u_cred0.cnt_q, 4'd0);

    // tie: alternate s0, s1, s0, s1 with a gap between each arw
    do_reset();
    s0_arw_valid = 1'b1; s0_arw_id = 7'd1;
    s1_arw_valid = 1'b1; s1_arw_id = 7'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("tie_idle_m_valid", m_arw_valid, 1'b0);
      check_eq("tie_s0_ready", s0_arw_ready, (k % 2) == 0);
      check_eq("tie_s1_ready", s1_arw_ready, (k % 2) == 1);
      step();
      #1;
      check_eq("tie_hold_m_valid", m_arw_valid, 1'b1);
      check_eq("tie_hold_id", m_arw_payload_id, ((k % 2) == 0) ? 8'h01 : 8'h82);
      check_eq("tie_hold_s0_ready", s0_arw_ready, 1'b0);
      step();
    end
    s0_arw_valid = 1'b0; s1_arw_valid = 1'b0;
    #1;
    check_eq("tie_cnt0", dut.u_cred0.cnt_q, 4'd2);
    check_eq("tie_cnt1", dut.u_cred1.cnt_q, 4'd2);

    // write lock: s1 writes 8 beats while s0 waits with a read and drives W
    do_reset();
    s1_arw_valid = 1'b1; s1_arw_write = 1'b1; s1_arw_len = 8'd7; s1_arw_id = 7'd3;
    #1;
    check_eq("wl_s1_ready", s1_arw_ready, 1'b1);
    step();
    s1_arw_valid = 1'b0;
    s0_arw_valid = 1'b1; s0_arw_id = 7'd9;
    s0_w_valid = 1'b1; s0_w_data = 128'hDEAD; s0_w_last = 1'b1;
    #1;
    check_eq("wl_hold_write", m_arw_payload_write, 1'b1);
    check_eq("wl_hold_id", m_arw_payload_id, 8'h83);
    check_eq("wl_hold_s0_ready", s0_arw_ready, 1'b0);
    check_eq("wl_hold_w_valid", m_w_valid, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        m_w_ready = 1'b0; s1_w_valid = 1'b1; s1_w_data = 128'(16'hB0 + i); s1_w_last = 1'b0;
        #1;
        check_eq("wl_stall_s1_ready", s1_w_ready, 1'b0);
        step();
        m_w_ready = 1'b1;
      end
      s1_w_valid = 1'b1; s1_w_data = 128'(16'hB0 + i); s1_w_last = (i == 7);
      #1;
      check_eq("wl_m_w_valid", m_w_valid, 1'b1);
      check_eq("wl_m_w_data", m_w_payload_data, 128'(16'hB0 + i));
      check_eq("wl_m_w_id", m_w_payload_id, 8'h83);
      check_eq("wl_m_w_last", m_w_payload_last, (i == 7));
      check_eq("wl_s1_w_ready", s1_w_ready, 1'b1);
      check_eq("wl_s0_w_ready", s0_w_ready, 1'b0);
      check_eq("wl_s0_arw_ready", s0_arw_ready, 1'b0);
      step();
    end
    s1_w_valid = 1'b0; s1_w_last = 1'b0; s0_w_valid = 1'b0;
    #1;
    check_eq("wl_after_s0_arw_ready", s0_arw_ready, 1'b1);
    check_eq("wl_after_w_valid", m_w_valid, 1'b0);
    step();
    s0_arw_valid = 1'b0;
    #1;
    check_eq("wl_s0_arw_id", m_arw_payload_id, 8'h09);

    // credit limit: 4 reads accepted, the 5th is held off until an R last returns
    do_reset();
    s0_arw_valid = 1'b1; s0_arw_id = 7'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("cl_ready_open", s0_arw_ready, 1'b1);
      step();
      step();
    end
    #1;
    check_eq("cl_cnt0_full", dut.u_cred0.cnt_q, 4'd4);
    check_eq("cl_ready_5th", s0_arw_ready, 1'b0);
    step();
    #1;
    check_eq("cl_ready_5th_b", s0_arw_ready, 1'b0);
    m_r_valid = 1'b1; m_r_payload_id = 8'h04; m_r_payload_last = 1'b1;
    #1;
    check_eq("cl_ready_same_cycle", s0_arw_ready, 1'b0);
    step();
    m_r_valid = 1'b0; m_r_payload_last = 1'b0;
    #1;
    check_eq("cl_ready_after_r", s0_arw_ready, 1'b1);
    step();
    s0_arw_valid = 1'b0;
    #1;
    check_eq("cl_cnt0_refill", dut.u_cred0.cnt_q, 4'd4);

    // stray B for port 1 with nothing outstanding
    do_reset();
    m_b_valid = 1'b1; m_b_payload_id = 8'h80;
    #1;
    check_eq("st_s1_b_valid", s1_b_valid, 1'b1);
    check_eq("st_s0_b_valid", s0_b_valid, 1'b0);
    check_eq("st_s1_b_id", s1_b_id, 7'd0);
    check_eq("st_m_b_ready", m_b_ready, 1'b1);
    check_eq("st_err_before", arb_err, 1'b0);
    step();
    m_b_valid = 1'b0;
    #1;
    check_eq("st_err_after", arb_err, 1'b1);
    check_eq("st_cnt1", dut.u_cred1.cnt_q, 4'd0);
    step();
    #1;
    check_eq("st_err_sticky", arb_err, 1'b1);

    // asynchronous reset during the third write beat
    do_reset();
    s0_arw_valid = 1'b1; s0_arw_write = 1'b1; s0_arw_len = 8'd7; s0_arw_id = 7'd6;
    step();
    s0_arw_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      s0_w_valid = 1'b1; s0_w_data = 128'(i);
      step();
    end
    s0_w_valid = 1'b1; s0_w_data = 128'd2;
    #1;
    check_eq("mr_w_valid_pre", m_w_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_w_valid", m_w_valid, 1'b0);
    check_eq("mr_s0_w_ready", s0_w_ready, 1'b0);
    check_eq("mr_m_arw_valid", m_arw_valid, 1'b0);
    check_eq("mr_arw_id", m_arw_payload_id, 8'h00);
    check_eq("mr_cnt0", dut.u_cred0.cnt_q, 4'd0);
    step();
    clr_inputs();
    rst_n = 1'b1;
    step();
    s0_arw_valid = 1'b1; s0_arw_id = 7'd7;
    s1_arw_valid = 1'b1; s1_arw_id = 7'd8;
    #1;
    check_eq("mr_post_s0_ready", s0_arw_ready, 1'b1);
    check_eq("mr_post_s1_ready", s1_arw_ready, 1'b0);
    step();
    s0_arw_valid = 1'b0; s1_arw_valid = 1'b0;
    #1;
    check_eq("mr_post_id", m_arw_payload_id, 8'h07);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
